// File: rtl/simulador_caixa_if.sv
// Water-tank plant bundle: valve/draw/fault commands in, level sensors and plant status out.
// The slave side is the plant model; the master side is the controller or the bench.
interface simulador_caixa_if #(
  parameter int NIVEL_W = 8
);
  logic               Ve;
  logic               Consumo;
  logic               Falha_en;
  logic [1:0]         Falha_sel;
  logic               Alta;
  logic               Media;
  logic               Baixa;
  logic [NIVEL_W-1:0] Nivel;
  logic [1:0]         Estado;
  logic               Transbordo;
  logic               Seco;

  modport master (
    output Ve, Consumo, Falha_en, Falha_sel,
    input  Alta, Media, Baixa, Nivel, Estado, Transbordo, Seco
  );

  modport slave (
    input  Ve, Consumo, Falha_en, Falha_sel,
    output Alta, Media, Baixa, Nivel, Estado, Transbordo, Seco
  );
endinterface

// File: rtl/simulador_caixa.sv
// Water-tank plant model: prescaled saturating level, hysteretic level sensors,
// overflow/dry mode FSM and sensor fault injection.
// Ports: clk, reset (async, active high), io (slave side of simulador_caixa_if).
module simulador_caixa #(
  parameter int NIVEL_W      = 8,
  parameter int NIVEL_MAX    = 255,
  parameter int NIVEL_INI    = 0,
  parameter int LIM_BAIXA    = 64,
  parameter int LIM_MEDIA    = 128,
  parameter int LIM_ALTA     = 192,
  parameter int HIST         = 4,
  parameter int TAXA_ENCHE   = 2,
  parameter int TAXA_CONSUMO = 1,
  parameter int DIV_TICK     = 1000
) (
  input  logic clk,
  input  logic reset,
  simulador_caixa_if.slave io
);

  localparam int CNT_W = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int DW    = NIVEL_W + 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TICK - 1);

  localparam logic signed [DW-1:0] ENCHE   = DW'(TAXA_ENCHE);
  localparam logic signed [DW-1:0] CONSUMO = DW'(TAXA_CONSUMO);
  localparam logic signed [DW-1:0] MAX_S   = DW'(NIVEL_MAX);

  localparam logic [NIVEL_W-1:0] NIV_MAX = NIVEL_W'(NIVEL_MAX);
  localparam logic [NIVEL_W-1:0] NIV_INI = NIVEL_W'(NIVEL_INI);

  // sensor index: 0 Baixa, 1 Media, 2 Alta
  localparam logic [2:0][NIVEL_W-1:0] LIM_SET = {
    NIVEL_W'(LIM_ALTA),
    NIVEL_W'(LIM_MEDIA),
    NIVEL_W'(LIM_BAIXA)
  };
  localparam logic [2:0][NIVEL_W-1:0] LIM_CLR = {
    NIVEL_W'(LIM_ALTA - HIST),
    NIVEL_W'(LIM_MEDIA - HIST),
    NIVEL_W'(LIM_BAIXA - HIST)
  };
  localparam logic [2:0] S_INI = {
    NIVEL_INI >= LIM_ALTA,
    NIVEL_INI >= LIM_MEDIA,
    NIVEL_INI >= LIM_BAIXA
  };

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    CHEIO  = 2'b01,
    VAZIO  = 2'b10
  } estado_t;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NIVEL_W-1:0] nivel_q, nivel_d;
  estado_t            estado_q, estado_d;
  logic               transbordo_q, transbordo_d;
  logic               seco_q, seco_d;
  logic [2:0]         s_q, s_d;
  logic [2:0]         sen_q, sen_d;

  logic               tick;
  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] soma;

  // prescaler
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // level update, saturating at 0 and NIVEL_MAX
  always_comb begin
    delta = '0;
    if (io.Ve) begin
      delta = delta + ENCHE;
    end
    if (io.Consumo) begin
      delta = delta - CONSUMO;
    end
    soma    = $signed({2'b00, nivel_q}) + delta;
    nivel_d = nivel_q;
    if (tick) begin
      if (soma > MAX_S) begin
        nivel_d = NIV_MAX;
      end else if (soma < 0) begin
        nivel_d = '0;
      end else begin
        nivel_d = soma[NIVEL_W-1:0];
      end
    end
  end

  // mode FSM
  always_comb begin
    estado_d = estado_q;
    if (tick) begin
      case (estado_q)
        NORMAL: begin
          if (soma > MAX_S) begin
            estado_d = CHEIO;
          end else if (soma < 0) begin
            estado_d = VAZIO;
          end
        end
        CHEIO: begin
          if (delta < 0) begin
            estado_d = NORMAL;
          end
        end
        VAZIO: begin
          if (delta > 0) begin
            estado_d = NORMAL;
          end
        end
        default: estado_d = NORMAL;
      endcase
    end
    transbordo_d = (estado_d == CHEIO);
    seco_d       = (estado_d == VAZIO);
  end

  // hysteretic sensors; the output register takes the next sensor state so
  // the pins lag Nivel by a single cycle
  always_comb begin
    s_d = s_q;
    for (int i = 0; i < 3; i++) begin
      if (nivel_q >= LIM_SET[i]) begin
        s_d[i] = 1'b1;
      end else if (nivel_q < LIM_CLR[i]) begin
        s_d[i] = 1'b0;
      end
    end
    sen_d = s_d;
    if (io.Falha_en) begin
      unique case (io.Falha_sel)
        2'b00: sen_d[0] = 1'b0;
        2'b01: sen_d[1] = 1'b0;
        2'b10: sen_d[2] = 1'b1;
        2'b11: sen_d[1] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      nivel_q      <= NIV_INI;
      estado_q     <= NORMAL;
      transbordo_q <= 1'b0;
      seco_q       <= 1'b0;
      s_q          <= S_INI;
      sen_q        <= S_INI;
    end else begin
      cnt_q        <= cnt_d;
      nivel_q      <= nivel_d;
      estado_q     <= estado_d;
      transbordo_q <= transbordo_d;
      seco_q       <= seco_d;
      s_q          <= s_d;
      sen_q        <= sen_d;
    end
  end

  assign io.Baixa      = sen_q[0];
  assign io.Media      = sen_q[1];
  assign io.Alta       = sen_q[2];
  assign io.Nivel      = nivel_q;
  assign io.Estado     = estado_q;
  assign io.Transbordo = transbordo_q;
  assign io.Seco       = seco_q;

endmodule

// File: doc/simulador_caixa.md
Name: simulador_caixa

Overview:
- Sequential plant model of the water tank. It closes the loop around the level controller: it consumes the controller's valve command (Ve) and produces the three level-sensor signals (Alta, Media, Baixa) the controller reads.
- Holds a saturating water-level accumulator updated on a prescaled tick, and derives the sensor outputs with hysteresis.
- Tracks overflow and dry-run conditions in a mode FSM.
- Supports sensor fault injection so the controller's Erro/Alarme paths can be exercised on the board.

Parameters:
- NIVEL_W, 8, level accumulator width.
- NIVEL_MAX, 255, full-tank level.
- NIVEL_INI, 0, level loaded at reset.
- LIM_BAIXA, 64, Baixa sensor threshold.
- LIM_MEDIA, 128, Media sensor threshold.
- LIM_ALTA, 192, Alta sensor threshold.
- HIST, 4, sensor hysteresis band in level units.
- TAXA_ENCHE, 2, level gain per tick with Ve=1.
- TAXA_CONSUMO, 1, level loss per tick with Consumo=1.
- DIV_TICK, 1000, clock cycles per tick.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Ve  in  1  inlet valve open (from the controller).
- Consumo  in  1  outlet draw active.
- Falha_en  in  1  fault injection enable.
- Falha_sel  in  2  fault select.
- Alta  out  1  high-level sensor.
- Media  out  1  mid-level sensor.
- Baixa  out  1  low-level sensor.
- Nivel  out  NIVEL_W  current level.
- Estado  out  2  mode: 00 NORMAL, 01 CHEIO, 10 VAZIO.
- Transbordo  out  1  high while Estado=CHEIO.
- Seco  out  1  high while Estado=VAZIO.

Behaviour:
- Reset (async, immediate; applies mid-operation at any time):
  - Prescaler = 0; Nivel = NIVEL_INI; Estado = NORMAL; Transbordo = 0; Seco = 0.
  - Sensors = (NIVEL_INI >= LIM_x) for each x; all 0 with default parameters.
- Prescaler:
  - Counts 0..DIV_TICK-1.
  - tick is an internal 1-cycle pulse in the cycle where count = DIV_TICK-1; the count wraps to 0 on the next edge.
- Level update, only on tick:
  - delta = (Ve ? TAXA_ENCHE : 0) - (Consumo ? TAXA_CONSUMO : 0), computed signed in NIVEL_W+2 bits.
  - soma = Nivel + delta.
  - Nivel <= clamp(soma, 0, NIVEL_MAX).
  - Ve and Consumo are sampled only in the tick cycle; values between ticks are ignored.
  - Ve=1 and Consumo=1 together gives net +1 (defaults).
- Mode FSM, transitions only on tick:
  - NORMAL -> CHEIO if soma > NIVEL_MAX.
  - NORMAL -> VAZIO if soma < 0.
  - CHEIO -> NORMAL if delta < 0.
  - CHEIO -> VAZIO: not possible (NIVEL_MAX >> rates).
  - VAZIO -> NORMAL if delta > 0.
  - delta = 0 holds the current state.
  - Transbordo and Seco are registered decodes of the state, updating on the same edge as Estado.
- Sensors, per sensor x (Baixa/Media/Alta):
  - Internal registered state s_x, updated every cycle from the registered Nivel, so there is 1 cycle latency after a Nivel change.
  - s_x sets when Nivel >= LIM_x.
  - s_x clears when Nivel < LIM_x - HIST.
  - Otherwise s_x holds.
- Fault injection:
  - Output register = forced value when Falha_en=1, else s_x.
  - Falha_sel 00: Baixa stuck 0.
  - Falha_sel 01: Media stuck 0.
  - Falha_sel 10: Alta stuck 1.
  - Falha_sel 11: Media stuck 1.
  - The fault takes effect on the first edge after Falha_en rises and releases on the first edge after it falls.
  - Faults never alter Nivel, s_x or Estado.
- Parameter legality:
  - LIM_BAIXA < LIM_MEDIA < LIM_ALTA <= NIVEL_MAX.
  - HIST < LIM_BAIXA.
  - TAXA_* < 2^NIVEL_W.
  - DIV_TICK >= 1. DIV_TICK = 1 means tick every cycle.

Test Plan (DIV_TICK=4, other defaults):
- Reset: assert reset mid-count with Nivel=100 -> same instant all outputs 0, Nivel=0, Estado=00. Release, Ve=1 -> first tick 4 cycles later, Nivel=2.
- Fill: from 0, Ve=1, Consumo=0 for 32 ticks (128 cycles) -> Nivel=64, Baixa=1 one cycle later. At Nivel=128, Media=1. At 192, Alta=1.
- Hysteresis: Nivel=66, Ve=0, Consumo=1:
  - Baixa stays 1 through Nivel=60.
  - Baixa clears one cycle after Nivel=59.
  - Refill: Baixa stays 0 until Nivel=64.
- Overflow: Nivel=254, Ve=1 -> next tick Nivel=255, Estado=01, Transbordo=1.
  - Further Ve ticks: Nivel stays 255.
  - Ve=0, Consumo=1 -> next tick Nivel=254, Estado=00, Transbordo=0.
- Dry/simultaneous: Nivel=0, Consumo=1 -> tick: Nivel=0, Seco=1.
  - Ve=1 and Consumo=1 -> next tick Nivel=1, Seco=0.
- Fault: Nivel=0, Falha_en=1, Falha_sel=10 -> next edge Alta=1, Media=0, Baixa=0, Nivel unchanged; with the controller attached, its Erro=1.
  - Falha_en=0 -> next edge Alta=0.
